t05_tree_build_sched: RTL and testbench

//  Sequences Huffman tree construction over the shared frequency store: 256 char slots (addr 0-255), node slots at 256+k.

---
 rtl/t05_tree_build_sched.sv | 183 ++++++++++++++++++
 tb/tb_t05_tree_build_sched.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t05_tree_build_sched.sv
// Huffman tree build sequencer: repeated min-two scans over the shared
// frequency store, merging the two least counts into a new node slot.
// Ports:
//   clk, rst                       clock, async active-high reset
//   start                          begin a build (sampled in IDLE)
//   rd_req/rd_addr/rd_ack/rd_data  store read port (req/ack)
//   wr_req/wr_addr/wr_data/wr_ack  store write port (req/ack)
//   node_valid/node_l/node_r/node_ready  tree link output (valid/ready)
//   busy, done, root, node_cnt, err      build status
module t05_tree_build_sched #(
    parameter int N_CHARS = 256,
    parameter int N_NODES = 255,
    parameter int CW      = 64,
    parameter int AW      = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          rd_req,
    output logic [AW-1:0] rd_addr,
    input  logic          rd_ack,
    input  logic [CW-1:0] rd_data,
    output logic          wr_req,
    output logic [AW-1:0] wr_addr,
    output logic [CW-1:0] wr_data,
    input  logic          wr_ack,
    output logic          node_valid,
    output logic [AW-1:0] node_l,
    output logic [AW-1:0] node_r,
    input  logic          node_ready,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] root,
    output logic [AW-1:0] node_cnt,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE, SCAN, EVAL, WIPE1, WIPE2, WNODE, EMIT, FIN
    } state_t;

    state_t        state, state_nx;
    logic [AW-1:0] idx;
    logic [AW-1:0] least1, least2;
    logic [CW-1:0] val1, val2;
    logic [1:0]    nz;
    logic [AW-1:0] last_idx;
    logic [AW-1:0] node_addr;
    logic          full;

    // Live slots: all chars plus every node created so far this build.
    assign last_idx  = AW'(N_CHARS - 1) + node_cnt;
    assign node_addr = AW'(N_CHARS) + node_cnt;
    assign full      = (node_cnt == AW'(N_NODES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        rd_req     = 1'b0;
        rd_addr    = '0;
        wr_req     = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        node_valid = 1'b0;
        node_l     = '0;
        node_r     = '0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = SCAN;
            end
            SCAN: begin
                busy    = 1'b1;
                rd_req  = 1'b1;
                rd_addr = idx;
                if (rd_ack && idx == last_idx) state_nx = EVAL;
            end
            EVAL: begin
                busy = 1'b1;
                if (nz != 2'd2 || full) state_nx = FIN;
                else                    state_nx = WIPE1;
            end
            WIPE1: begin
                busy    = 1'b1;
                wr_req  = 1'b1;
                wr_addr = least1;
                if (wr_ack) state_nx = WIPE2;
            end
            WIPE2: begin
                busy    = 1'b1;
                wr_req  = 1'b1;
                wr_addr = least2;
                if (wr_ack) state_nx = WNODE;
            end
            WNODE: begin
                busy    = 1'b1;
                wr_req  = 1'b1;
                wr_addr = node_addr;
                wr_data = val1 + val2;
                if (wr_ack) state_nx = EMIT;
            end
            EMIT: begin
                busy       = 1'b1;
                node_valid = 1'b1;
                node_l     = least1;
                node_r     = least2;
                if (node_ready) state_nx = SCAN;
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            val1     <= '1;
            val2     <= '1;
            least1   <= '0;
            least2   <= '0;
            nz       <= '0;
            root     <= '0;
            node_cnt <= '0;
            err      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        node_cnt <= '0;
                        err      <= 1'b0;
                        root     <= '0;
                        idx      <= '0;
                        val1     <= '1;
                        val2     <= '1;
                        nz       <= '0;
                    end
                end
                SCAN: begin
                    if (rd_ack) begin
                        idx <= idx + 1'b1;
                        // Strict compares: on ties the earlier address stays.
                        if (rd_data != '0) begin
                            if (nz != 2'd2) nz <= nz + 1'b1;
                            if (rd_data < val1) begin
                                val2   <= val1;
                                least2 <= least1;
                                val1   <= rd_data;
                                least1 <= idx;
                            end else if (rd_data < val2) begin
                                val2   <= rd_data;
                                least2 <= idx;
                            end
                        end
                    end
                end
                EVAL: begin
                    if (nz == 2'd0)      err  <= 1'b1;
                    else if (nz == 2'd1) root <= least1;
                    else if (full)       err  <= 1'b1;
                end
                EMIT: begin
                    if (node_ready) begin
                        node_cnt <= node_cnt + 1'b1;
                        val1     <= '1;
                        val2     <= '1;
                        nz       <= '0;
                        idx      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_t05_tree_build_sched.sv
// Directed bench for t05_tree_build_sched: behavioural store, link
// logger, handshake stability monitor and scenario tasks.
module tb_t05_tree_build_sched;

    localparam int AW = 9;
    localparam int CW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          rd_req, wr_req, node_valid, busy, done, err;
    logic [AW-1:0] rd_addr, wr_addr, node_l, node_r, root, node_cnt;
    logic [CW-1:0] rd_data, wr_data;
    logic          rd_ack = 1'b1;
    logic          wr_ack = 1'b1;
    logic          node_ready = 1'b1;

    logic [CW-1:0] mem [0:511];
    logic [CW-1:0] pre [0:511];
    int            pre_gen = 0;
    int            seen_gen = -1;

    int checks = 0;
    int failures = 0;

    bit rnd_mode = 1'b0;
    int nv_cnt = 0;
    int done_cnt = 0;
    int stab_viol = 0;

    int            wq_a [$];
    logic [CW-1:0] wq_d [$];
    int            nq_l [$];
    int            nq_r [$];

    logic          p_rd = 1'b0, p_wr = 1'b0, p_nv = 1'b0;
    logic [AW-1:0] p_ra, p_wa, p_nl, p_nr;
    logic [CW-1:0] p_wd;

    int            c1_wa [6] = '{67, 66, 256, 256, 65, 257};
    logic [CW-1:0] c1_wd [6] = '{64'd0, 64'd0, 64'd3, 64'd0, 64'd0, 64'd8};
    int            c1_nl [2] = '{67, 256};
    int            c1_nr [2] = '{66, 65};

    t05_tree_build_sched dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack),
        .rd_data    (rd_data),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .node_valid (node_valid),
        .node_l     (node_l),
        .node_r     (node_r),
        .node_ready (node_ready),
        .busy       (busy),
        .done       (done),
        .root       (root),
        .node_cnt   (node_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    assign rd_data = mem[rd_addr];

    // Store, transfer log and done counter; sole writer of all of them.
    always @(posedge clk) begin
        if (pre_gen != seen_gen) begin
            for (int i = 0; i < 512; i++) mem[i] = pre[i];
            seen_gen = pre_gen;
        end
        if (!rst) begin
            if (wr_req && wr_ack) begin
                mem[wr_addr] = wr_data;
                wq_a.push_back(int'(wr_addr));
                wq_d.push_back(wr_data);
            end
            if (node_valid && node_ready) begin
                nq_l.push_back(int'(node_l));
                nq_r.push_back(int'(node_r));
            end
            if (done) done_cnt++;
        end
    end

    // Ack/ready generation and hold-until-accepted monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (p_rd && (!rd_req || rd_addr !== p_ra)) stab_viol++;
            if (p_wr && (!wr_req || wr_addr !== p_wa || wr_data !== p_wd))
                stab_viol++;
            if (p_nv && (!node_valid || node_l !== p_nl || node_r !== p_nr))
                stab_viol++;
        end
        if (rnd_mode) begin
            rd_ack = ($urandom_range(99) < 30);
            wr_ack = ($urandom_range(99) < 30);
            if (node_valid) begin
                nv_cnt++;
                node_ready = (nv_cnt > 5);
            end else begin
                nv_cnt = 0;
                node_ready = 1'b0;
            end
        end else begin
            rd_ack = 1'b1;
            wr_ack = 1'b1;
            node_ready = 1'b1;
            nv_cnt = 0;
        end
        p_rd = !rst && rd_req && !rd_ack;
        p_wr = !rst && wr_req && !wr_ack;
        p_nv = !rst && node_valid && !node_ready;
        p_ra = rd_addr;
        p_wa = wr_addr;
        p_wd = wr_data;
        p_nl = node_l;
        p_nr = node_r;
    end

    task automatic clear_pre();
        for (int i = 0; i < 512; i++) pre[i] = '0;
    endtask

    task automatic commit();
        pre_gen++;
        @(posedge clk);
        #1;
    endtask

    task automatic load_case1();
        clear_pre();
        pre[65] = 64'd5;
        pre[66] = 64'd2;
        pre[67] = 64'd1;
        commit();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input string tag);
        int n;
        n = 0;
        while (done_cnt == base && n < 20000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (done_cnt !== base + 1) begin
            failures++;
            $display("FAIL %s_done: got %0d pulses, need 1", tag,
                     done_cnt - base);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle: busy=%b done=%b, need 0 0", tag,
                     busy, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_pre();
        commit();
        @(negedge clk);
        checks++;
        if ({rd_req, wr_req, node_valid, busy, done, err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b, need 000000",
                     {rd_req, wr_req, node_valid, busy, done, err});
        end
        checks++;
        if ({root, node_cnt, rd_addr, wr_addr, node_l, node_r} !== '0 ||
            wr_data !== '0) begin
            failures++;
            $display("FAIL reset_buses: root=%0d cnt=%0d ra=%0d wa=%0d wd=%0d",
                     root, node_cnt, rd_addr, wr_addr, wr_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int wb, nb, db;
        load_case1();
        wb = wq_a.size();
        nb = nq_l.size();
        db = done_cnt;
        pulse_start();
        wait_done(db, "basic");
        checks++;
        if (wq_a.size() - wb !== 6 || nq_l.size() - nb !== 2) begin
            failures++;
            $display("FAIL basic_counts: wr=%0d links=%0d, need 6 2",
                     wq_a.size() - wb, nq_l.size() - nb);
        end
        for (int i = 0; i < 6; i++) begin
            if (wb + i < wq_a.size()) begin
                checks++;
                if (wq_a[wb+i] !== c1_wa[i] || wq_d[wb+i] !== c1_wd[i]) begin
                    failures++;
                    $display("FAIL basic_wr%0d: got %0d@%0d, need %0d@%0d", i,
                             wq_d[wb+i], wq_a[wb+i], c1_wd[i], c1_wa[i]);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (nb + i < nq_l.size()) begin
                checks++;
                if (nq_l[nb+i] !== c1_nl[i] || nq_r[nb+i] !== c1_nr[i]) begin
                    failures++;
                    $display("FAIL basic_link%0d: got (%0d,%0d), need (%0d,%0d)",
                             i, nq_l[nb+i], nq_r[nb+i], c1_nl[i], c1_nr[i]);
                end
            end
        end
        checks++;
        if (root !== 9'd257 || node_cnt !== 9'd2 || err !== 1'b0) begin
            failures++;
            $display("FAIL basic_status: root=%0d cnt=%0d err=%b, need 257 2 0",
                     root, node_cnt, err);
        end
    endtask

    task automatic test_tie();
        int wb, nb, db;
        clear_pre();
        pre[10] = 64'd4;
        pre[20] = 64'd4;
        commit();
        wb = wq_a.size();
        nb = nq_l.size();
        db = done_cnt;
        pulse_start();
        // A second start mid-build must be ignored.
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(db, "tie");
        checks++;
        if (wq_a.size() - wb !== 3 || nq_l.size() - nb !== 1) begin
            failures++;
            $display("FAIL tie_counts: wr=%0d links=%0d, need 3 1",
                     wq_a.size() - wb, nq_l.size() - nb);
        end else begin
            checks++;
            if (nq_l[nb] !== 10 || nq_r[nb] !== 20) begin
                failures++;
                $display("FAIL tie_link: got (%0d,%0d), need (10,20)",
                         nq_l[nb], nq_r[nb]);
            end
            checks++;
            if (wq_a[wb+2] !== 256 || wq_d[wb+2] !== 64'd8) begin
                failures++;
                $display("FAIL tie_node: got %0d@%0d, need 8@256",
                         wq_d[wb+2], wq_a[wb+2]);
            end
        end
        checks++;
        if (root !== 9'd256 || node_cnt !== 9'd1 || err !== 1'b0) begin
            failures++;
            $display("FAIL tie_status: root=%0d cnt=%0d err=%b, need 256 1 0",
                     root, node_cnt, err);
        end
    endtask

    task automatic test_back_to_back();
        int wb, db;
        // Store left by the tie build holds only node 256; a fresh build
        // scans chars alone and sees nothing.
        wb = wq_a.size();
        db = done_cnt;
        pulse_start();
        wait_done(db, "b2b");
        checks++;
        if (err !== 1'b1 || root !== 9'd0 || wq_a.size() !== wb) begin
            failures++;
            $display("FAIL b2b_status: err=%b root=%0d wr=%0d, need 1 0 0",
                     err, root, wq_a.size() - wb);
        end
    endtask

    task automatic test_all_zero();
        int wb, nb, db;
        clear_pre();
        commit();
        wb = wq_a.size();
        nb = nq_l.size();
        db = done_cnt;
        pulse_start();
        wait_done(db, "zero");
        checks++;
        if (wq_a.size() !== wb || nq_l.size() !== nb) begin
            failures++;
            $display("FAIL zero_traffic: wr=%0d links=%0d, need 0 0",
                     wq_a.size() - wb, nq_l.size() - nb);
        end
        checks++;
        if (err !== 1'b1 || node_cnt !== 9'd0) begin
            failures++;
            $display("FAIL zero_status: err=%b cnt=%0d, need 1 0",
                     err, node_cnt);
        end
    endtask

    task automatic test_single();
        int wb, db;
        clear_pre();
        pre[200] = 64'd9;
        commit();
        wb = wq_a.size();
        db = done_cnt;
        pulse_start();
        wait_done(db, "single");
        checks++;
        if (wq_a.size() !== wb || root !== 9'd200 || err !== 1'b0) begin
            failures++;
            $display("FAIL single_status: wr=%0d root=%0d err=%b, need 0 200 0",
                     wq_a.size() - wb, root, err);
        end
    endtask

    task automatic test_random();
        int wb, nb, db, sb;
        load_case1();
        wb = wq_a.size();
        nb = nq_l.size();
        db = done_cnt;
        sb = stab_viol;
        rnd_mode = 1'b1;
        pulse_start();
        wait_done(db, "rnd");
        rnd_mode = 1'b0;
        checks++;
        if (wq_a.size() - wb !== 6 || nq_l.size() - nb !== 2) begin
            failures++;
            $display("FAIL rnd_counts: wr=%0d links=%0d, need 6 2",
                     wq_a.size() - wb, nq_l.size() - nb);
        end
        for (int i = 0; i < 6; i++) begin
            if (wb + i < wq_a.size()) begin
                checks++;
                if (wq_a[wb+i] !== c1_wa[i] || wq_d[wb+i] !== c1_wd[i]) begin
                    failures++;
                    $display("FAIL rnd_wr%0d: got %0d@%0d, need %0d@%0d", i,
                             wq_d[wb+i], wq_a[wb+i], c1_wd[i], c1_wa[i]);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (nb + i < nq_l.size()) begin
                checks++;
                if (nq_l[nb+i] !== c1_nl[i] || nq_r[nb+i] !== c1_nr[i]) begin
                    failures++;
                    $display("FAIL rnd_link%0d: got (%0d,%0d), need (%0d,%0d)",
                             i, nq_l[nb+i], nq_r[nb+i], c1_nl[i], c1_nr[i]);
                end
            end
        end
        checks++;
        if (stab_viol !== sb) begin
            failures++;
            $display("FAIL rnd_stable: %0d unstable holds, need 0",
                     stab_viol - sb);
        end
        checks++;
        if (root !== 9'd257 || node_cnt !== 9'd2 || err !== 1'b0) begin
            failures++;
            $display("FAIL rnd_status: root=%0d cnt=%0d err=%b, need 257 2 0",
                     root, node_cnt, err);
        end
    endtask

    task automatic test_reset_mid();
        int wb, nb, db;
        load_case1();
        wb = wq_a.size();
        db = done_cnt;
        pulse_start();
        repeat (50) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || rd_req !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_scan: busy=%b rd_req=%b, need 1 1",
                     busy, rd_req);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({rd_req, wr_req, node_valid, busy, done, err} !== 6'b0 ||
            rd_addr !== '0 || node_cnt !== '0 || root !== '0) begin
            failures++;
            $display("FAIL rstmid_zero: flags=%b ra=%0d cnt=%0d root=%0d",
                     {rd_req, wr_req, node_valid, busy, done, err},
                     rd_addr, node_cnt, root);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (wq_a.size() !== wb || done_cnt !== db) begin
            failures++;
            $display("FAIL rstmid_abort: wr=%0d done=%0d, need 0 0",
                     wq_a.size() - wb, done_cnt - db);
        end
        load_case1();
        wb = wq_a.size();
        nb = nq_l.size();
        db = done_cnt;
        pulse_start();
        wait_done(db, "rstmid");
        checks++;
        if (wq_a.size() - wb !== 6 || nq_l.size() - nb !== 2) begin
            failures++;
            $display("FAIL rstmid_counts: wr=%0d links=%0d, need 6 2",
                     wq_a.size() - wb, nq_l.size() - nb);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (wq_a[wb+i] !== c1_wa[i] || wq_d[wb+i] !== c1_wd[i]) begin
                    failures++;
                    $display("FAIL rstmid_wr%0d: got %0d@%0d, need %0d@%0d", i,
                             wq_d[wb+i], wq_a[wb+i], c1_wd[i], c1_wa[i]);
                end
            end
        end
        checks++;
        if (root !== 9'd257 || node_cnt !== 9'd2 || err !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_status: root=%0d cnt=%0d err=%b, need 257 2 0",
                     root, node_cnt, err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_back_to_back();
        test_all_zero();
        test_single();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
